// File: rtl/vproc_pkg.sv
// ----------------------------------------------------------------------------
// vproc_pkg
// Shared constants for the vector core: operation codes, FSM state encodings
// and width/decode helpers used by the core, its lane ALU and its interface.
// Optional feature macro: VPROC_MAC_EN (enables op 100, multiply-accumulate).
// ----------------------------------------------------------------------------
package vproc_pkg;

    // Operation codes carried on op_code
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_MAC   = 3'b100;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_STORE = 3'd2;
    localparam logic [2:0] ST_ADD   = 3'd3;
    localparam logic [2:0] ST_MUL   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    // Index width for an n-entry structure, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_MUL: return 1'b1;
`ifdef VPROC_MAC_EN
            OP_MAC:                            return 1'b1;
`endif
            default:                           return 1'b0;
        endcase
    endfunction

    // MAC shares the serial multiply state; only the lane ALU tells them apart
    function automatic logic [2:0] op_state(input logic [2:0] op);
        case (op)
            OP_LOAD:  return ST_LOAD;
            OP_STORE: return ST_STORE;
            OP_ADD:   return ST_ADD;
            OP_MUL:   return ST_MUL;
            OP_MAC:   return ST_MUL;
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/vproc_vector_core_if.sv
// ----------------------------------------------------------------------------
// vproc_vector_core_if
// Operation handshake, external memory write port and debug read port of the
// vector core.
//   master (sequencer/testbench): drives op_valid, op_code, src_a, src_b, dst,
//     mem_addr, mem_wr_en, mem_wr_addr, mem_wr_data, dbg_rd_addr;
//     receives op_ready, done, err, dbg_rd_data.
//   slave (vproc_vector_core): the mirror image.
// ----------------------------------------------------------------------------
interface vproc_vector_core_if #(
    parameter int ELEM_W    = 32,
    parameter int NUM_REGS  = 4,
    parameter int MEM_DEPTH = 512
);
    import vproc_pkg::*;

    localparam int ADDR_W = idx_w(MEM_DEPTH);
    localparam int REG_W  = idx_w(NUM_REGS);

    logic              op_valid;
    logic              op_ready;
    logic [2:0]        op_code;
    logic [REG_W-1:0]  src_a;
    logic [REG_W-1:0]  src_b;
    logic [REG_W-1:0]  dst;
    logic [ADDR_W-1:0] mem_addr;
    logic              done;
    logic              err;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [ELEM_W-1:0] mem_wr_data;
    logic [ADDR_W-1:0] dbg_rd_addr;
    logic [ELEM_W-1:0] dbg_rd_data;

    modport master (
        output op_valid, op_code, src_a, src_b, dst, mem_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data, dbg_rd_addr,
        input  op_ready, done, err, dbg_rd_data
    );

    modport slave (
        input  op_valid, op_code, src_a, src_b, dst, mem_addr,
               mem_wr_en, mem_wr_addr, mem_wr_data, dbg_rd_addr,
        output op_ready, done, err, dbg_rd_data
    );

endinterface

// File: rtl/vproc_lane_alu.sv
// ----------------------------------------------------------------------------
// vproc_lane_alu
// Single-lane signed datapath. Produces a double-width result split in two:
//   ADD : o_lo = low ELEM_W bits of the (ELEM_W+1)-bit sum,
//         o_hi = sign of that sum replicated across ELEM_W bits
//   MUL : {o_hi, o_lo} = signed 2*ELEM_W product
//   MAC : {o_hi, o_lo} = i_acc + product, modulo 2^(2*ELEM_W)
// Ports: i_op (op code), i_a/i_b (signed operands), i_acc (accumulator, only
// when VPROC_MAC_EN is defined), o_lo/o_hi (result halves).
// Lanes that are tied to OP_ADD let synthesis prune their multiplier.
// ----------------------------------------------------------------------------
module vproc_lane_alu
    import vproc_pkg::*;
#(
    parameter int ELEM_W = 32
) (
    input  logic [2:0]                 i_op,
    input  logic signed [ELEM_W-1:0]   i_a,
    input  logic signed [ELEM_W-1:0]   i_b,
`ifdef VPROC_MAC_EN
    input  logic signed [2*ELEM_W-1:0] i_acc,
`endif
    output logic [ELEM_W-1:0]          o_lo,
    output logic [ELEM_W-1:0]          o_hi
);

    logic signed [ELEM_W:0]     w_sum;
    logic signed [2*ELEM_W-1:0] w_prod;
`ifdef VPROC_MAC_EN
    logic signed [2*ELEM_W-1:0] w_mac;
`endif

    // Operands are sign-extended to the result width before the operation
    assign w_sum  = i_a + i_b;
    assign w_prod = i_a * i_b;
`ifdef VPROC_MAC_EN
    assign w_mac  = i_acc + w_prod;
`endif

    always_comb begin
        o_lo = w_sum[ELEM_W-1:0];
        o_hi = {ELEM_W{w_sum[ELEM_W]}};
        case (i_op)
            OP_MUL: {o_hi, o_lo} = w_prod;
`ifdef VPROC_MAC_EN
            OP_MAC: {o_hi, o_lo} = w_mac;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/vproc_vector_core.sv
// ----------------------------------------------------------------------------
// vproc_vector_core
// Handshaked vector execution core: NUM_REGS x LANES x ELEM_W register file,
// MEM_DEPTH-element data memory, one LOAD/STORE/ADD/MUL(/MAC) at a time.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset (memory contents are retained)
//   bus  - vproc_vector_core_if.slave: op handshake, done/err pulses,
//          external memory write port, registered debug read port
// Optional feature macro: VPROC_MAC_EN (op 100 multiply-accumulate).
// ----------------------------------------------------------------------------
module vproc_vector_core
    import vproc_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int ELEM_W    = 32,
    parameter int NUM_REGS  = 4,
    parameter int MEM_DEPTH = 512
) (
    input  logic               clk,
    input  logic               rst,
    vproc_vector_core_if.slave bus
);

    localparam int ADDR_W = idx_w(MEM_DEPTH);
    localparam int REG_W  = idx_w(NUM_REGS);
    localparam int LANE_W = idx_w(LANES);

    logic [2:0]               r_state;
    logic [2:0]               r_op;
    logic [REG_W-1:0]         r_dst;
    logic [ADDR_W-1:0]        r_base;
    logic [LANE_W-1:0]        r_lane;
    logic                     r_done;
    logic                     r_err;
    logic [ELEM_W-1:0]        r_dbg;
    logic signed [ELEM_W-1:0] r_rf [NUM_REGS][LANES];
    logic signed [ELEM_W-1:0] r_va [LANES];
    logic signed [ELEM_W-1:0] r_vb [LANES];
    logic [ELEM_W-1:0]        r_mem [MEM_DEPTH];

    logic                     w_op_ready;
    logic                     w_accept;
    logic                     w_wr_ok;
    logic                     w_wr_drop;
    logic                     w_store_wr;
    logic                     w_last;
    logic [REG_W-1:0]         w_dst1;
    logic [ADDR_W-1:0]        w_addr;
    logic [ELEM_W-1:0]        w_lo [LANES];
    logic [ELEM_W-1:0]        w_hi [LANES];

    assign w_op_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept   = bus.op_valid && w_op_ready;
    assign w_wr_ok    = bus.mem_wr_en && w_op_ready;
    assign w_wr_drop  = bus.mem_wr_en && !w_op_ready;
    assign w_store_wr = (r_state == ST_STORE) && !rst;
    assign w_last     = (r_lane == LANE_W'(LANES - 1));
    // Power-of-two sizes make plain truncation the required modulo wrap
    assign w_dst1     = r_dst + REG_W'(1);
    assign w_addr     = r_base + ADDR_W'(r_lane);

    assign bus.op_ready    = w_op_ready;
    assign bus.done        = r_done;
    assign bus.err         = r_err;
    assign bus.dbg_rd_data = r_dbg;

    // Lane 0 serves both ADD lane 0 and the serial MUL/MAC; the lane counter
    // is zero during ADD, so indexing by it covers both uses.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if (g == 0) begin : g_serial
            vproc_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
                .i_op  (r_op),
                .i_a   (r_va[r_lane]),
                .i_b   (r_vb[r_lane]),
`ifdef VPROC_MAC_EN
                .i_acc ({r_rf[w_dst1][r_lane], r_rf[r_dst][r_lane]}),
`endif
                .o_lo  (w_lo[g]),
                .o_hi  (w_hi[g])
            );
        end else begin : g_add
            vproc_lane_alu #(.ELEM_W(ELEM_W)) u_alu (
                .i_op  (OP_ADD),
                .i_a   (r_va[g]),
                .i_b   (r_vb[g]),
`ifdef VPROC_MAC_EN
                .i_acc ('0),
`endif
                .o_lo  (w_lo[g]),
                .o_hi  (w_hi[g])
            );
        end
    end

    // Control FSM and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_dst   <= '0;
            r_base  <= '0;
            r_lane  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                for (int l = 0; l < LANES; l++) begin
                    r_rf[r][l] <= '0;
                end
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= w_wr_drop;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (op_legal(bus.op_code)) begin
                            r_op    <= bus.op_code;
                            r_dst   <= bus.dst;
                            r_base  <= bus.mem_addr;
                            r_lane  <= '0;
                            r_state <= op_state(bus.op_code);
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: r_rf[r_dst][r_lane] <= w_mem_rd();
                ST_STORE: ;
                ST_ADD: begin
                    for (int l = 0; l < LANES; l++) begin
                        r_rf[r_dst][l]  <= w_lo[l];
                        r_rf[w_dst1][l] <= w_hi[l];
                    end
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_MUL: begin
                    r_rf[r_dst][r_lane]  <= w_lo[0];
                    r_rf[w_dst1][r_lane] <= w_hi[0];
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            // Element-serial operations step one lane per cycle
            if ((r_state == ST_LOAD) || (r_state == ST_STORE) || (r_state == ST_MUL)) begin
                if (w_last) begin
                    r_lane  <= '0;
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_lane <= r_lane + LANE_W'(1);
                end
            end
        end
    end

    function automatic logic [ELEM_W-1:0] w_mem_rd();
        return r_mem[w_addr];
    endfunction

    // Source vectors captured at acceptance so dst may alias a source
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int l = 0; l < LANES; l++) begin
                r_va[l] <= r_rf[bus.src_a][l];
                r_vb[l] <= r_rf[bus.src_b][l];
            end
        end
    end

    // Data memory: external writes only while idle, STORE writes one lane per cycle
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[bus.mem_wr_addr] <= bus.mem_wr_data;
        end else if (w_store_wr) begin
            r_mem[w_addr] <= r_va[r_lane];
        end
    end

    // Debug read samples the array before any same-edge write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dbg <= '0;
        end else begin
            r_dbg <= r_mem[bus.dbg_rd_addr];
        end
    end

endmodule

// File: doc/vproc_vector_core.md
# vproc_vector_core

Parametrised, handshaked vector execution core: the next generation of `vector_processor`. It holds a register file of NUM_REGS vectors, each LANES elements of ELEM_W bits, and a MEM_DEPTH-element data memory. It executes load, store, add and multiply one operation at a time under a valid/ready handshake, with element-serial memory access and a single shared multiplier. It sits between the instruction sequencer and the testbench/debug memory port.

## Interface
- LANES, 4, elements per vector; power of 2, ≥2
- ELEM_W, 32, element width in bits
- NUM_REGS, 4, vector registers; power of 2, ≥4
- MEM_DEPTH, 512, memory depth in elements; power of 2; ADDR_W = $clog2(MEM_DEPTH)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  operation request
- op_ready  out  1  core idle, can accept
- op_code  in  3  000 LOAD, 001 STORE, 010 ADD, 011 MUL, 100 MAC (macro-gated), others illegal
- src_a, src_b, dst  in  $clog2(NUM_REGS) each  register selects
- mem_addr  in  ADDR_W  vector base element address
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse
- mem_wr_en, mem_wr_addr (ADDR_W), mem_wr_data (ELEM_W)  in  external element write
- dbg_rd_addr  in  ADDR_W; dbg_rd_data  out  ELEM_W  registered debug read

## Operation
- FSM: IDLE, LOAD, STORE, ADD, MUL, DONE. op_ready = (state==IDLE) && !rst.
- Accept on op_valid && op_ready; latch op_code, src_a, src_b, dst, mem_addr; clear lane counter.
- LOAD: lane i: R[dst][i] ← mem[(mem_addr+i) mod MEM_DEPTH]. STORE: mem[(mem_addr+i) mod MEM_DEPTH] ← R[src_a][i].
- ADD: all lanes in one cycle; signed (ELEM_W+1)-bit sum; R[dst] ← low ELEM_W bits; R[(dst+1) mod NUM_REGS] ← sign-extension of bit ELEM_W (all ones or zero).
- MUL: one lane per cycle; signed 2·ELEM_W product; low half → R[dst], high half → R[(dst+1) mod NUM_REGS].
- Sources are read from values latched at acceptance; dst == src is legal.
- Illegal op_code: accepted, no state change, err pulses, no done.
- mem_wr_en honoured only while op_ready; otherwise dropped and err pulses. Write plus op accept on the same edge: both take effect; a LOAD sees the new data.
- dbg_rd_data ← mem[dbg_rd_addr] every cycle. A same-cycle STORE write returns the old value (read-before-write).
- Reset: state IDLE, all registers 0, lane counter 0, done/err/dbg_rd_data 0. Memory has no reset and retains contents. Reset mid-operation aborts with no done.

## Timing
- With acceptance at edge k, LOAD/STORE/MUL/MAC process lane i at edge k+1+i. Then DONE follows, so done is high in the cycle after edge k+LANES.
- ADD: done is high in the cycle after edge k+1.
- DONE → IDLE unconditionally; op_ready is high the cycle after done.
- err is high in the cycle after the offending edge.

## Configuration
- VPROC_MAC_EN defined: op 100 MAC is enabled. Per lane, {R[dst+1],R[dst]} ← {R[dst+1],R[dst]} + signed product of src_a and src_b, computed modulo 2^(2·ELEM_W). Latency is the same as MUL.
- VPROC_MAC_EN undefined: op 100 is illegal (err pulse). No accumulator adder is synthesised.

## Structure
- vproc_pkg holds the op_code constants, the FSM state enum and the $clog2-derived width helpers.
- Sub-module vproc_lane_alu is a single-lane signed add, multiply and optional MAC datapath. ADD instantiates it LANES times; MUL/MAC reuse lane 0's multiplier serially.

## Test plan
- Reset: hold rst for 2 cycles → op_ready=0, done=0, err=0. After release, op_ready=1 and every R[*][*]=0.
- Preload mem[0..3]={1,2,3,4} and mem[16..19]={10,20,30,40}. Run LOAD dst0@0, LOAD dst1@16, ADD a0 b1 dst2, STORE src2@32.
  - mem[32..35] reads {11,22,33,44} via dbg.
  - R3 = all zero.
  - Each LOAD raises done 4 cycles after acceptance; ADD raises done 1 cycle after.
- MUL with R0={0x7FFFFFFF,-3,0,-1} and R1={0x7FFFFFFF,5,9,-1}, dst2:
  - R2={0x00000001,0xFFFFFFF1,0,1}.
  - R3={0x3FFFFFFF,0xFFFFFFFF,0,0}.
- Wrap: LOAD dst0 from base 510 → elements taken from addresses 510, 511, 0, 1.
- Assert rst in MUL lane 2 → next cycle IDLE, op_ready=1, no done, registers 0, memory unchanged.
- Errors:
  - op_code 111 → err pulse, op_ready stays 1, no done.
  - mem_wr_en during LOAD → err pulse, memory unchanged.
  - op 100 without VPROC_MAC_EN → err pulse. With VPROC_MAC_EN, a MAC after the MUL above gives R2[1]=0xFFFFFFE2, R3[1]=0xFFFFFFFF.
